// File: rtl/icmp_vlg_ping.sv
// ICMP echo-request initiator: builds a type-8 request, waits for the matching type-0 reply, reports ok/timeout and RTT.
// Define ICMP_PING_CHECKSUM_CHK_EN to also require a valid ones'-complement checksum on received replies.
module icmp_vlg_ping #(
    parameter int          PAYLOAD_LEN   = 32,
    parameter int          TIMEOUT_TICKS = 1_000_000,
    parameter logic [15:0] ICMP_ID       = 16'h4556
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dev_ipv4_i,
    input  logic        req_i,
    input  logic [31:0] dst_ipv4_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ok_o,
    output logic [31:0] rtt_o,
    output logic [15:0] seq_o,
    output logic [7:0]  tx_dat_o,
    output logic        tx_val_o,
    output logic        tx_sof_o,
    output logic        tx_eof_o,
    input  logic        tx_rdy_i,
    output logic [31:0] tx_src_ip_o,
    output logic [31:0] tx_dst_ip_o,
    output logic [7:0]  tx_proto_o,
    output logic [15:0] tx_len_o,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_val_i,
    input  logic        rx_sof_i,
    input  logic        rx_eof_i,
    input  logic        rx_err_i,
    input  logic [31:0] rx_src_ip_i,
    input  logic [7:0]  rx_proto_i
);
    localparam logic [10:0] FRAME_LEN = 11'(8 + PAYLOAD_LEN);
    localparam logic [10:0] FRAME_LST = 11'(7 + PAYLOAD_LEN);
    localparam logic [10:0] PREP_LST  = 11'(PAYLOAD_LEN - 1);
    localparam logic [31:0] TIMEOUT   = 32'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {IDLE, PREP, SEND, WAIT} state_t;

    function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [15:0] sum_q, sum_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] src_q, src_d;
    logic [31:0] rtt_cnt_q, rtt_cnt_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [31:0] rtt_q, rtt_d;
    logic [15:0] seq_q, seq_d;

    logic        rx_act_q, rx_act_d;
    logic [10:0] rx_idx_q, rx_idx_d;
    logic        rx_good_q, rx_good_d;
    logic        rx_match;

    logic [15:0] cksum;
    logic [10:0] pay_idx;
    logic [31:0] elapsed;

    assign cksum = ~sum_q;

    // ---------------- TX byte stream ----------------
    always_comb begin
        tx_val_o = 1'b0;
        tx_sof_o = 1'b0;
        tx_eof_o = 1'b0;
        tx_dat_o = 8'h00;
        pay_idx  = cnt_q - 11'd8;
        if (state_q == SEND) begin
            tx_val_o = 1'b1;
            tx_sof_o = (cnt_q == 11'd0);
            tx_eof_o = (cnt_q == FRAME_LST);
            case (cnt_q)
                11'd0:   tx_dat_o = 8'h08;
                11'd1:   tx_dat_o = 8'h00;
                11'd2:   tx_dat_o = cksum[15:8];
                11'd3:   tx_dat_o = cksum[7:0];
                11'd4:   tx_dat_o = ICMP_ID[15:8];
                11'd5:   tx_dat_o = ICMP_ID[7:0];
                11'd6:   tx_dat_o = seq_q[15:8];
                11'd7:   tx_dat_o = seq_q[7:0];
                default: tx_dat_o = pay_idx[7:0] ^ seq_q[7:0];
            endcase
        end
    end

    // ---------------- RX reply matcher ----------------
    logic [10:0] rx_byte_idx;
    logic [10:0] rx_pay_idx;
    logic        rx_byte_ok;
    logic        rx_frame_on;
    logic        rx_good;
    logic        cks_ok;
`ifdef ICMP_PING_CHECKSUM_CHK_EN
    logic [15:0] rx_acc_q, rx_acc_d;
    logic [7:0]  rx_hi_q, rx_hi_d;
    logic [15:0] acc_base, acc_word, acc_next;
`endif

    always_comb begin
        rx_act_d    = rx_act_q;
        rx_idx_d    = rx_idx_q;
        rx_good_d   = rx_good_q;
        rx_match    = 1'b0;
        rx_byte_idx = rx_sof_i ? 11'd0 : rx_idx_q;
        rx_pay_idx  = rx_byte_idx - 11'd8;
        case (rx_byte_idx)
            11'd0:   rx_byte_ok = (rx_dat_i == 8'h00);
            11'd1:   rx_byte_ok = (rx_dat_i == 8'h00);
            11'd2:   rx_byte_ok = 1'b1;
            11'd3:   rx_byte_ok = 1'b1;
            11'd4:   rx_byte_ok = (rx_dat_i == ICMP_ID[15:8]);
            11'd5:   rx_byte_ok = (rx_dat_i == ICMP_ID[7:0]);
            11'd6:   rx_byte_ok = (rx_dat_i == seq_q[15:8]);
            11'd7:   rx_byte_ok = (rx_dat_i == seq_q[7:0]);
            default: rx_byte_ok = (rx_dat_i == (rx_pay_idx[7:0] ^ seq_q[7:0]));
        endcase
        // header metadata qualifies the frame once, at its first byte
        rx_frame_on = rx_sof_i ? ((rx_proto_i == 8'd1) && (rx_src_ip_i == dst_q)) : rx_act_q;
        rx_good     = (rx_sof_i || rx_good_q) && rx_byte_ok && (rx_byte_idx < FRAME_LEN);
`ifdef ICMP_PING_CHECKSUM_CHK_EN
        rx_acc_d = rx_acc_q;
        rx_hi_d  = rx_hi_q;
        acc_base = rx_sof_i ? 16'h0000 : rx_acc_q;
        acc_word = rx_byte_idx[0] ? {rx_hi_q, rx_dat_i} : {rx_dat_i, 8'h00};
        acc_next = add1c(acc_base, acc_word);
        cks_ok   = (acc_next == 16'hFFFF);
`else
        cks_ok = 1'b1;
`endif
        if (state_q != WAIT) begin
            rx_act_d = 1'b0;
        end else if (rx_val_i && rx_frame_on) begin
            if (rx_eof_i) begin
                rx_act_d = 1'b0;
                rx_match = rx_good && (rx_byte_idx == FRAME_LST) && !rx_err_i && cks_ok;
            end else begin
                rx_act_d  = 1'b1;
                rx_idx_d  = rx_byte_idx + 11'd1;
                rx_good_d = rx_good;
`ifdef ICMP_PING_CHECKSUM_CHK_EN
                if (rx_byte_idx[0]) begin
                    rx_acc_d = acc_next;
                end else begin
                    rx_acc_d = acc_base;
                    rx_hi_d  = rx_dat_i;
                end
`endif
            end
        end else if (rx_val_i && rx_sof_i) begin
            rx_act_d = 1'b0;
        end
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        dst_d     = dst_q;
        src_d     = src_q;
        rtt_cnt_d = rtt_cnt_q;
        done_d    = 1'b0;
        ok_d      = ok_q;
        rtt_d     = rtt_q;
        seq_d     = seq_q;
        elapsed   = (rtt_cnt_q == 32'hFFFF_FFFF) ? rtt_cnt_q : rtt_cnt_q + 32'd1;
        case (state_q)
            IDLE: begin
                if (req_i && !done_q) begin
                    dst_d   = dst_ipv4_i;
                    src_d   = dev_ipv4_i;
                    sum_d   = add1c(add1c(16'h0800, ICMP_ID), seq_q);
                    cnt_d   = 11'd0;
                    state_d = PREP;
                end
            end
            PREP: begin
                // odd byte completes a payload word; its high byte has index cnt-1
                if (cnt_q[0]) begin
                    sum_d = add1c(sum_q, {{cnt_q[7:1], 1'b0} ^ seq_q[7:0], cnt_q[7:0] ^ seq_q[7:0]});
                end
                if (cnt_q == PREP_LST) begin
                    cnt_d   = 11'd0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            SEND: begin
                if (tx_rdy_i) begin
                    if (cnt_q == FRAME_LST) begin
                        cnt_d     = 11'd0;
                        rtt_cnt_d = 32'd0;
                        state_d   = WAIT;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            WAIT: begin
                rtt_cnt_d = elapsed;
                if (rx_match) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    rtt_d   = elapsed;
                    seq_d   = seq_q + 16'd1;
                    state_d = IDLE;
                end else if (elapsed >= TIMEOUT) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    rtt_d   = TIMEOUT;
                    seq_d   = seq_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 11'd0;
            sum_q     <= 16'd0;
            dst_q     <= 32'd0;
            src_q     <= 32'd0;
            rtt_cnt_q <= 32'd0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            rtt_q     <= 32'd0;
            seq_q     <= 16'd0;
            rx_act_q  <= 1'b0;
            rx_idx_q  <= 11'd0;
            rx_good_q <= 1'b0;
`ifdef ICMP_PING_CHECKSUM_CHK_EN
            rx_acc_q  <= 16'd0;
            rx_hi_q   <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            rtt_cnt_q <= rtt_cnt_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            rtt_q     <= rtt_d;
            seq_q     <= seq_d;
            rx_act_q  <= rx_act_d;
            rx_idx_q  <= rx_idx_d;
            rx_good_q <= rx_good_d;
`ifdef ICMP_PING_CHECKSUM_CHK_EN
            rx_acc_q  <= rx_acc_d;
            rx_hi_q   <= rx_hi_d;
`endif
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign ok_o        = ok_q;
    assign rtt_o       = rtt_q;
    assign seq_o       = seq_q;
    assign tx_src_ip_o = src_q;
    assign tx_dst_ip_o = dst_q;
    assign tx_proto_o  = 8'd1;
    assign tx_len_o    = {5'd0, FRAME_LEN};

endmodule

// File: tb/tb_icmp_vlg_ping.sv
// Bench for icmp_vlg_ping: randomized TX backpressure and RX framing checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_icmp_vlg_ping;
    localparam int PL  = 32;
    localparam int FL  = PL + 8;
    localparam int TMO = 500;
    localparam logic [15:0] ID  = 16'h4556;
    localparam logic [31:0] DST = 32'hC0A80001;
    localparam logic [31:0] DEV = 32'hC0A80064;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] dst_ipv4 = 32'd0;
    logic        busy, done, ok;
    logic [31:0] rtt;
    logic [15:0] seq;
    logic [7:0]  tx_dat;
    logic        tx_val, tx_sof, tx_eof;
    logic        tx_rdy = 1'b1;
    logic [31:0] tx_src_ip, tx_dst_ip;
    logic [7:0]  tx_proto;
    logic [15:0] tx_len;
    logic [7:0]  rx_dat = 8'd0;
    logic        rx_val = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, rx_err = 1'b0;
    logic [31:0] rx_src_ip = 32'd0;
    logic [7:0]  rx_proto = 8'd0;

    icmp_vlg_ping #(.PAYLOAD_LEN(PL), .TIMEOUT_TICKS(TMO), .ICMP_ID(ID)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dev_ipv4_i(DEV), .req_i(req), .dst_ipv4_i(dst_ipv4),
        .busy_o(busy), .done_o(done), .ok_o(ok), .rtt_o(rtt), .seq_o(seq),
        .tx_dat_o(tx_dat), .tx_val_o(tx_val), .tx_sof_o(tx_sof), .tx_eof_o(tx_eof), .tx_rdy_i(tx_rdy),
        .tx_src_ip_o(tx_src_ip), .tx_dst_ip_o(tx_dst_ip), .tx_proto_o(tx_proto), .tx_len_o(tx_len),
        .rx_dat_i(rx_dat), .rx_val_i(rx_val), .rx_sof_i(rx_sof), .rx_eof_i(rx_eof), .rx_err_i(rx_err),
        .rx_src_ip_i(rx_src_ip), .rx_proto_i(rx_proto)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_ok = 1'b0;
    logic [31:0] done_rtt = 32'd0;
    logic        done_busy = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_ok   <= ok;
            done_rtt  <= rtt;
            done_busy <= busy;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: ICMP header + payload, checksum from plain integer word sums.
    logic [7:0] mdl_f [FL];
    logic [7:0] rep_f [FL];
    logic [7:0] cap_f [FL];

    task automatic build_frame(input logic [7:0] typ, input logic [15:0] sq);
        int          s;
        logic [15:0] ck;
        mdl_f[0] = typ;       mdl_f[1] = 8'h00;
        mdl_f[2] = 8'h00;     mdl_f[3] = 8'h00;
        mdl_f[4] = ID[15:8];  mdl_f[5] = ID[7:0];
        mdl_f[6] = sq[15:8];  mdl_f[7] = sq[7:0];
        for (int i = 0; i < PL; i++) mdl_f[8 + i] = 8'(i) ^ sq[7:0];
        s = 0;
        for (int w = 0; w < FL / 2; w++) s += {16'd0, mdl_f[2 * w], mdl_f[2 * w + 1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        ck = ~16'(s);
        mdl_f[2] = ck[15:8];
        mdl_f[3] = ck[7:0];
    endtask

    task automatic load_reply(input logic [15:0] sq);
        build_frame(8'h00, sq);
        for (int i = 0; i < FL; i++) rep_f[i] = mdl_f[i];
    endtask

    int req_cyc, cap_n, cap_sof_idx, cap_eof_idx, tx_first_cyc, tx_eof_cyc, rx_eof_cyc;

    task automatic ping(input logic [31:0] dst);
        req = 1'b1;
        dst_ipv4 = dst;
        req_cyc = cyc;
        @(negedge clk);
        req = 1'b0;
        dst_ipv4 = $urandom;
        chk("busy_after_req", {31'd0, busy}, 32'd1);
        chk("tx_dst_ip", tx_dst_ip, dst);
    endtask

    // Collects TX bytes; stop_at >= 0 returns while that byte index is being offered.
    task automatic capture(input bit rnd, input int stop_at);
        bit rdy;
        cap_n = 0; cap_sof_idx = -1; cap_eof_idx = -1; tx_first_cyc = -1; tx_eof_cyc = -1;
        for (int b = 0; b < 3000; b++) begin
            if (stop_at >= 0 && tx_val && cap_n == stop_at) return;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_rdy = rdy;
            if (tx_val && tx_first_cyc < 0) tx_first_cyc = cyc;
            if (tx_val && rdy) begin
                if (cap_n < FL) cap_f[cap_n] = tx_dat;
                if (tx_sof && cap_sof_idx < 0) cap_sof_idx = cap_n;
                if (tx_eof) begin
                    cap_eof_idx = cap_n;
                    tx_eof_cyc = cyc;
                    cap_n++;
                    @(negedge clk);
                    tx_rdy = 1'b1;
                    chk("tx_val_drop", {31'd0, tx_val}, 32'd0);
                    return;
                end
                cap_n++;
            end
            @(negedge clk);
        end
        chk("tx_frame_budget", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input logic [15:0] sq);
        build_frame(8'h08, sq);
        chk("tx_byte_count", cap_n, FL);
        chk("tx_sof_pos", cap_sof_idx, 0);
        chk("tx_eof_pos", cap_eof_idx, FL - 1);
        for (int i = 0; i < FL; i++) chk($sformatf("tx_byte[%0d]", i), {24'd0, cap_f[i]}, {24'd0, mdl_f[i]});
    endtask

    task automatic drive_frame(input logic [31:0] src, input bit err, input bit gaps);
        for (int i = 0; i < FL; i++) begin
            if (gaps) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    rx_val = 1'b0;
                    rx_dat = 8'($urandom);
                    @(negedge clk);
                end
            end
            rx_val = 1'b1;
            rx_dat = rep_f[i];
            rx_sof = (i == 0);
            rx_eof = (i == FL - 1);
            rx_err = err && (i == FL - 1);
            rx_src_ip = src;
            rx_proto = 8'd1;
            if (i == FL - 1) rx_eof_cyc = cyc;
            @(negedge clk);
        end
        rx_val = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base);
        for (int b = 0; b < budget; b++) begin
            #1;
            if (done_cnt != base) return;
            @(negedge clk);
        end
        chk("done_budget", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int base;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ok", {31'd0, ok}, 32'd0);
        chk("rst_rtt", rtt, 32'd0);
        chk("rst_seq", {16'd0, seq}, 32'd0);
        chk("rst_tx_val", {31'd0, tx_val}, 32'd0);
        chk("rst_tx_dat", {24'd0, tx_dat}, 32'd0);
        chk("rst_tx_proto", {24'd0, tx_proto}, 32'd1);
        chk("rst_tx_len", {16'd0, tx_len}, FL);
        chk("rst_tx_dst", tx_dst_ip, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // full-rate request, reply ending 100 cycles after tx_eof
        ping(DST);
        chk("tx_src_ip", tx_src_ip, DEV);
        capture(1'b0, -1);
        check_frame(16'd0);
        chk("tx_val_rise", tx_first_cyc - req_cyc, PL + 1);
        while (cyc < tx_eof_cyc + 100 - (FL - 1)) @(negedge clk);
        load_reply(16'd0);
        base = done_cnt;
        drive_frame(DST, 1'b0, 1'b0);
        #1;
        chk("t1_done", done_cnt - base, 1);
        chk("t1_ok", {31'd0, done_ok}, 32'd1);
        chk("t1_rtt", done_rtt, rx_eof_cyc - tx_eof_cyc);
        chk("t1_rtt100", done_rtt, 32'd100);
        chk("t1_done_cyc", done_cyc, rx_eof_cyc + 1);
        chk("t1_busy_at_done", {31'd0, done_busy}, 32'd0);
        chk("t1_seq", {16'd0, seq}, 32'd1);
        @(negedge clk);

        // no reply: timeout, and req while busy is ignored
        ping(32'h0A000002);
        capture(1'b0, -1);
        check_frame(16'd1);
        base = done_cnt;
        @(negedge clk);
        req = 1'b1; dst_ipv4 = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b0;
        chk("busy_req_ignored", tx_dst_ip, 32'h0A000002);
        wait_done(800, base);
        chk("t2_ok", {31'd0, done_ok}, 32'd0);
        chk("t2_rtt", done_rtt, TMO);
        chk("t2_done_cyc", done_cyc - tx_eof_cyc, TMO + 1);
        chk("t2_seq", {16'd0, seq}, 32'd2);
        repeat (3) @(negedge clk);
        chk("t2_no_queue", {31'd0, busy}, 32'd0);

        // random backpressure, then a run of bad replies before the good one
        ping(DST);
        capture(1'b1, -1);
        check_frame(16'd2);
        base = done_cnt;
        load_reply(16'd3);
        drive_frame(DST, 1'b0, 1'b1);
        #1 chk("bad_seq", done_cnt - base, 0);
        load_reply(16'd2);
        drive_frame(32'hC0A80002, 1'b0, 1'b1);
        #1 chk("bad_src", done_cnt - base, 0);
        load_reply(16'd2);
        rep_f[8 + $urandom_range(0, PL - 1)] ^= 8'h10;
        drive_frame(DST, 1'b0, 1'b1);
        #1 chk("bad_payload", done_cnt - base, 0);
        load_reply(16'd2);
        drive_frame(DST, 1'b1, 1'b1);
        #1 chk("bad_rx_err", done_cnt - base, 0);
        load_reply(16'd2);
        drive_frame(DST, 1'b0, 1'b1);
        #1;
        chk("t3_done", done_cnt - base, 1);
        chk("t3_ok", {31'd0, done_ok}, 32'd1);
        chk("t3_rtt", done_rtt, rx_eof_cyc - tx_eof_cyc);
        chk("t3_seq", {16'd0, seq}, 32'd3);
        @(negedge clk);

        // reply with a corrupted checksum field
        ping(DST);
        capture(1'b0, -1);
        check_frame(16'd3);
        load_reply(16'd3);
        rep_f[2] ^= 8'h5A;
        base = done_cnt;
        drive_frame(DST, 1'b0, 1'b0);
`ifdef ICMP_PING_CHECKSUM_CHK_EN
        wait_done(800, base);
        chk("cks_ok", {31'd0, done_ok}, 32'd0);
        chk("cks_rtt", done_rtt, TMO);
`else
        #1;
        chk("cks_done", done_cnt - base, 1);
        chk("cks_ok", {31'd0, done_ok}, 32'd1);
`endif
        chk("cks_seq", {16'd0, seq}, 32'd4);
        @(negedge clk);

        // reset in the middle of SEND, then a clean frame
        ping(DST);
        capture(1'b1, 10);
        chk("rst_mid_at_byte", cap_n, 10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_val", {31'd0, tx_val}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_seq", {16'd0, seq}, 32'd0);
        chk("rst_mid_ok", {31'd0, ok}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_rdy = 1'b1;
        @(negedge clk);
        ping(DST);
        capture(1'b0, -1);
        check_frame(16'd0);
        load_reply(16'd0);
        base = done_cnt;
        drive_frame(DST, 1'b0, 1'b1);
        #1;
        chk("t5_done", done_cnt - base, 1);
        chk("t5_ok", {31'd0, done_ok}, 32'd1);
        chk("t5_seq", {16'd0, seq}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
